// File: rtl/div_unit.sv
// Iterative RV32M divider: restoring shift-subtract, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the 32-step loop.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  func3,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] div_out,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        is_rem_q;
  logic        out_valid_q;
  logic [31:0] div_out_q;
`ifdef DIV_EARLY_OUT_EN
  logic        early_q;
  logic        ovf;
`endif

  logic        is_signed;
  logic        div_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] src_quo;
  logic [31:0] src_rem;
  logic [31:0] res;

  always_comb begin
    is_signed = ~func3[0];
    div_zero  = (operand2 == 32'h0);
    a_mag     = (is_signed && operand1[31]) ? (32'h0 - operand1) : operand1;
    b_mag     = (is_signed && operand2[31]) ? (32'h0 - operand2) : operand2;
`ifdef DIV_EARLY_OUT_EN
    ovf       = is_signed && (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);
`endif
  end

  // The partial remainder is always below the divisor, so the 33rd bit only
  // exists transiently in the shifted value.
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvsr_q};
    step_rem = diff[32] ? shifted[31:0] : diff[31:0];
    step_quo = {quo_q[30:0], ~diff[32]};
`ifdef DIV_EARLY_OUT_EN
    src_quo  = early_q ? quo_q : step_quo;
    src_rem  = early_q ? rem_q : step_rem;
`else
    src_quo  = step_quo;
    src_rem  = step_rem;
`endif
    if (is_rem_q) res = r_neg_q ? (32'h0 - src_rem) : src_rem;
    else          res = q_neg_q ? (32'h0 - src_quo) : src_quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 5'd0;
      rem_q       <= 32'h0;
      quo_q       <= 32'h0;
      dvsr_q      <= 32'h0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      is_rem_q    <= 1'b0;
      out_valid_q <= 1'b0;
      div_out_q   <= 32'h0;
`ifdef DIV_EARLY_OUT_EN
      early_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q  <= StCalc;
            cnt_q    <= 5'd0;
            rem_q    <= 32'h0;
            quo_q    <= a_mag;
            dvsr_q   <= b_mag;
            // A zero divisor must yield all-ones regardless of dividend sign.
            q_neg_q  <= is_signed && (operand1[31] ^ operand2[31]) && !div_zero;
            r_neg_q  <= is_signed && operand1[31];
            is_rem_q <= func3[1];
`ifdef DIV_EARLY_OUT_EN
            early_q  <= div_zero || ovf;
            if (div_zero) begin
              quo_q <= 32'hFFFF_FFFF;
              rem_q <= a_mag;
            end else if (ovf) begin
              quo_q <= 32'h8000_0000;
              rem_q <= 32'h0;
            end
`endif
          end
        end
        StCalc: begin
`ifdef DIV_EARLY_OUT_EN
          if (early_q) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            div_out_q   <= res;
          end else begin
`else
          begin
`endif
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              div_out_q   <= res;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            div_out_q   <= 32'h0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign div_out   = div_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; honours DIV_EARLY_OUT_EN for expected latency.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  func3;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] div_out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = 32;
`endif

  localparam logic [2:0] OpDiv  = 3'b100;
  localparam logic [2:0] OpDivu = 3'b101;
  localparam logic [2:0] OpRem  = 3'b110;
  localparam logic [2:0] OpRemu = 3'b111;

  always #5 clk = ~clk;

  div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .func3    (func3),
    .operand1 (operand1),
    .operand2 (operand2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .div_out  (div_out),
    .busy     (busy)
  );

  // Issues one op with out_ready high; checks latency, result and return to idle.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int waitc;
    in_valid = 1'b1;
    func3    = f3;
    operand1 = a;
    operand2 = b;
    waitc    = 0;
    while (in_ready !== 1'b1 && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    func3    = ~f3;
    operand1 = 32'hDEAD_BEEF;
    operand2 = 32'h0000_0003;
    n_cmp++;
    if ({busy, in_ready, out_valid, div_out} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL %s accept_state: busy=%b in_ready=%b out_valid=%b div_out=%h required 1 0 0 0",
               name, busy, in_ready, out_valid, div_out);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (div_out !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h required %h", name, div_out, exp);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready, div_out} !== {1'b0, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b div_out=%h required 0 1 0",
               name, out_valid, in_ready, div_out);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    func3     = OpDivu;
    operand1  = 32'h0;
    operand2  = 32'h0;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, div_out, busy, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_async: out_valid=%b div_out=%h busy=%b in_ready=%b required 0 0 0 1",
               out_valid, div_out, busy, in_ready);
    end
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_held: busy=%b in_ready=%b required 0 1", busy, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    do_op("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd14, 32);
    do_op("remu_100_7", OpRemu, 32'd100, 32'd7, 32'd2, 32);
    do_op("divu_max_1", OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32);
    do_op("remu_big", OpRemu, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32);
  endtask

  task automatic test_signed();
    do_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    do_op("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    do_op("rem_7_m2", OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);
    do_op("rem_m8_2", OpRem, 32'hFFFF_FFF8, 32'd2, 32'd0, 32);
  endtask

  task automatic test_special();
    do_op("div_5_0", OpDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat);
    do_op("rem_5_0", OpRem, 32'd5, 32'd0, 32'd5, SpecLat);
    do_op("div_m5_0", OpDiv, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SpecLat);
    do_op("rem_m5_0", OpRem, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SpecLat);
    do_op("remu_9_0", OpRemu, 32'd9, 32'd0, 32'd9, SpecLat);
    do_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat);
    do_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SpecLat);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_first", OpDivu, 32'd50, 32'd5, 32'd10, 32);
    do_op("b2b_second", OpRemu, 32'd51, 32'd5, 32'd1, 32);
  endtask

  task automatic test_backpressure();
    int waitc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    func3     = OpDivu;
    operand1  = 32'd100;
    operand2  = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitc = 0;
    while (out_valid !== 1'b1 && waitc < 40) begin
      @(posedge clk); #1;
      waitc++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      func3    = OpRemu;
      operand1 = 32'd1 + i;
      operand2 = 32'd1;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, div_out} !== {1'b1, 1'b0, 32'd14}) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b div_out=%h required 1 0 0000000e",
                 i, out_valid, in_ready, div_out);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready, busy, div_out} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b div_out=%h required 0 1 0 0",
               out_valid, in_ready, busy, div_out);
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    func3     = OpDivu;
    operand1  = 32'd1000;
    operand2  = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, div_out, busy, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid_calc: out_valid=%b div_out=%h busy=%b in_ready=%b required 0 0 0 1",
               out_valid, div_out, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_discard: active cycles after reset got %0d required 0", seen);
    end
    do_op("divu_9_3", OpDivu, 32'd9, 32'd3, 32'd3, 32);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
